// File: rtl/clock_enable_gen.sv
// Multi-channel clock divider / clock-enable generator.
// Each channel produces a 50%-duty divided clock with half period div_act cycles, plus a
// one-cycle tick on every rising edge of that divided clock. Divisor writes to a running
// channel are shadowed until the next half-period boundary, so no half period is cut short.
module clock_enable_gen #(
   parameter int unsigned NUM_CH = 3,
   parameter int unsigned CNT_W  = 28,
   parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {28'd1000000, 28'd100000, 28'd2},
   parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              en,
   input  logic [NUM_CH-1:0] ch_en,
   input  logic              sync,
   input  logic              wr_en,
   input  logic [CH_W-1:0]   wr_ch,
   input  logic [CNT_W-1:0]  wr_div,
   output logic [NUM_CH-1:0] div_clk,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] busy
);

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      localparam logic [CNT_W-1:0] DivRst = DIV_INIT[gi*CNT_W +: CNT_W];

      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] r_div_act;
      logic [CNT_W-1:0] r_div_shd;
      logic             r_pend;
      logic             r_div_clk;
      logic             r_tick;

      logic             w_run;
      logic             w_wrap;
      logic             w_wr_hit;

      // A zero divisor freezes the channel just like a cleared enable.
      assign w_run    = en & ch_en[gi] & (r_div_act != '0);
      assign w_wrap   = w_run & (r_cnt == (r_div_act - CNT_W'(1)));
      // Out-of-range channel indices never match any channel, so such writes are dropped.
      assign w_wr_hit = wr_en & (wr_ch == CH_W'(gi));

      // Channel state: reset, phase restart, then counting with shadowed divisor updates.
      always_ff @(posedge clk) begin
         if (clr) begin
            r_cnt     <= '0;
            r_div_clk <= 1'b0;
            r_tick    <= 1'b0;
            r_pend    <= 1'b0;
            r_div_act <= DivRst;
            r_div_shd <= DivRst;
         end else if (sync) begin
            r_cnt     <= '0;
            r_div_clk <= 1'b0;
            r_tick    <= 1'b0;
            if (r_pend) begin
               r_div_act <= r_div_shd;
               r_pend    <= 1'b0;
            end
            // A write coinciding with sync goes straight to the active divisor.
            if (w_wr_hit) begin
               r_div_act <= wr_div;
               r_pend    <= 1'b0;
            end
         end else begin
            if (!w_run) begin
               r_tick <= 1'b0;
            end else if (w_wrap) begin
               r_cnt     <= '0;
               r_div_clk <= ~r_div_clk;
               r_tick    <= ~r_div_clk;
               if (r_pend) begin
                  r_div_act <= r_div_shd;
                  r_pend    <= 1'b0;
               end
            end else begin
               r_cnt  <= r_cnt + CNT_W'(1);
               r_tick <= 1'b0;
            end

            // Later assignments override the wrap-time shadow load: the newest write wins.
            if (w_wr_hit) begin
               if (w_run && !w_wrap) begin
                  r_div_shd <= wr_div;
                  r_pend    <= 1'b1;
               end else begin
                  r_div_act <= wr_div;
                  r_pend    <= 1'b0;
                  if (!w_run) begin
                     r_cnt <= '0;
                  end
               end
            end
         end
      end

      assign div_clk[gi] = r_div_clk;
      assign tick[gi]    = r_tick;
      assign busy[gi]    = r_pend;
   end

endmodule

// File: tb/tb_clock_enable_gen.sv
// Bench for clock_enable_gen: directed scenarios followed by random traffic, every cycle
// compared against a behavioural model of the divider rules.
module tb_clock_enable_gen;

   localparam int unsigned NUM_CH = 3;
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned CH_W   = 2;
   localparam logic [NUM_CH*CNT_W-1:0] TB_DIV_INIT = {8'd10, 8'd4, 8'd1};

   logic              clk = 1'b0;
   logic              clr = 1'b1;
   logic              en = 1'b1;
   logic [NUM_CH-1:0] ch_en = '1;
   logic              sync = 1'b0;
   logic              wr_en = 1'b0;
   logic [CH_W-1:0]   wr_ch = '0;
   logic [CNT_W-1:0]  wr_div = '0;
   logic [NUM_CH-1:0] div_clk;
   logic [NUM_CH-1:0] tick;
   logic [NUM_CH-1:0] busy;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Reference model state (per channel)
   int m_elapsed [NUM_CH];  // cycles already spent in the current half period
   int m_half    [NUM_CH];  // active half-period length
   int m_next    [NUM_CH];  // queued half-period length
   bit m_queued  [NUM_CH];
   bit m_level   [NUM_CH];
   bit m_tick    [NUM_CH];

   clock_enable_gen #(
      .NUM_CH  (NUM_CH),
      .CNT_W   (CNT_W),
      .DIV_INIT(TB_DIV_INIT),
      .CH_W    (CH_W)
   ) dut (
      .clk    (clk),
      .clr    (clr),
      .en     (en),
      .ch_en  (ch_en),
      .sync   (sync),
      .wr_en  (wr_en),
      .wr_ch  (wr_ch),
      .wr_div (wr_div),
      .div_clk(div_clk),
      .tick   (tick),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   function automatic int init_div(int c);
      logic [NUM_CH*CNT_W-1:0] v;
      v = TB_DIV_INIT;
      return int'(v[c*CNT_W +: CNT_W]);
   endfunction

   // Advance the model by one clock edge using the inputs currently applied.
   task automatic model_step();
      if (clr) begin
         for (int c = 0; c < NUM_CH; c++) begin
            m_elapsed[c] = 0;
            m_level[c]   = 0;
            m_tick[c]    = 0;
            m_queued[c]  = 0;
            m_half[c]    = init_div(c);
            m_next[c]    = init_div(c);
         end
      end else if (sync) begin
         for (int c = 0; c < NUM_CH; c++) begin
            m_elapsed[c] = 0;
            m_level[c]   = 0;
            m_tick[c]    = 0;
            if (m_queued[c]) begin
               m_half[c]   = m_next[c];
               m_queued[c] = 0;
            end
         end
         if (wr_en && int'(wr_ch) < NUM_CH) begin
            m_half[wr_ch]   = int'(wr_div);
            m_queued[wr_ch] = 0;
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            bit running;
            bit half_done;
            bit hit;
            running   = en && ch_en[c] && (m_half[c] != 0);
            half_done = running && (m_elapsed[c] + 1 >= m_half[c]);
            hit       = wr_en && (int'(wr_ch) == c);
            m_tick[c] = 0;
            if (half_done) begin
               m_tick[c]    = !m_level[c];
               m_level[c]   = !m_level[c];
               m_elapsed[c] = 0;
               if (m_queued[c]) begin
                  m_half[c]   = m_next[c];
                  m_queued[c] = 0;
               end
            end else if (running) begin
               m_elapsed[c]++;
            end
            if (hit) begin
               if (running && !half_done) begin
                  m_next[c]   = int'(wr_div);
                  m_queued[c] = 1;
               end else begin
                  m_half[c]   = int'(wr_div);
                  m_queued[c] = 0;
                  if (!running) m_elapsed[c] = 0;
               end
            end
         end
      end
   endtask

   task automatic chk(string tag, logic [NUM_CH-1:0] obs, logic [NUM_CH-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [NUM_CH-1:0] e_clk;
      logic [NUM_CH-1:0] e_tick;
      logic [NUM_CH-1:0] e_busy;
      for (int c = 0; c < NUM_CH; c++) begin
         e_clk[c]  = m_level[c];
         e_tick[c] = m_tick[c];
         e_busy[c] = m_queued[c];
      end
      chk("div_clk", div_clk, e_clk);
      chk("tick", tick, e_tick);
      chk("busy", busy, e_busy);
   endtask

   task automatic step(int n);
      repeat (n) begin
         model_step();
         @(posedge clk);
         #1;
         cyc++;
         check_all();
      end
   endtask

   task automatic write(int c, int d);
      wr_en  = 1'b1;
      wr_ch  = CH_W'(c);
      wr_div = CNT_W'(d);
      step(1);
      wr_en  = 1'b0;
   endtask

   // Run until channel c is 'from_end' cycles before its half-period boundary.
   task automatic wait_phase(string tag, int c, int from_end, int budget);
      bit found;
      found = 0;
      for (int k = 0; k < budget && !found; k++) begin
         if (m_half[c] - 1 - m_elapsed[c] == from_end) found = 1;
         else step(1);
      end
      n_assert++;
      assert (found) else begin
         n_fail++;
         $error("FAIL %s cycle=%0d observed=timeout expected=phase %0d", tag, cyc, from_end);
      end
   endtask

   initial begin
      // Reset held three cycles, then free running at {10,4,1}
      clr = 1'b1; en = 1'b1; ch_en = '1;
      step(3);
      chk("reset_outputs", div_clk | tick | busy, '0);
      clr = 1'b0;
      step(45);

      // Reprogram running channel 1 mid half period: 4 -> 6
      wait_phase("wait_ch1_mid", 1, 2, 20);
      write(1, 6);
      chk("busy_after_write", busy, 3'b010);
      step(30);

      // Stopped-channel write, re-enable, then disable via D=0
      ch_en[2] = 1'b0;
      step(2);
      write(2, 3);
      chk("busy_stopped_write", busy & 3'b100, 3'b000);
      step(3);
      ch_en[2] = 1'b1;
      step(10);
      write(2, 0);
      step(30);
      chk("ch2_frozen_tick", tick & 3'b100, 3'b000);

      // Sync alignment at D=4 / D=6 with a divisor left pending
      write(0, 4);
      write(2, 9);
      step(13);
      wait_phase("wait_ch1_pend", 1, 3, 20);
      write(1, 6);
      sync = 1'b1;
      step(1);
      sync = 1'b0;
      chk("sync_outputs", div_clk | tick | busy, '0);
      step(60);

      // Write on the wrap cycle of channel 0 takes effect immediately
      wait_phase("wait_ch0_wrap", 0, 0, 20);
      write(0, 2);
      chk("wrap_write_busy", busy & 3'b001, 3'b000);
      step(12);

      // Out-of-range channel write is ignored
      write(3, 7);
      chk("bad_ch_busy", busy, '0);
      step(12);

      // clr together with sync and write
      clr = 1'b1; sync = 1'b1;
      write(1, 5);
      clr = 1'b0; sync = 1'b0;
      chk("clr_priority", div_clk | tick | busy, '0);
      step(25);

      // Global gating for 7 cycles mid-count
      wait_phase("wait_ch2_mid", 2, 4, 20);
      en = 1'b0;
      step(7);
      chk("gated_tick", tick, '0);
      en = 1'b1;
      step(30);

      // Random traffic
      for (int k = 0; k < 800; k++) begin
         en     = ($urandom_range(0, 15) != 0);
         if ($urandom_range(0, 20) == 0) ch_en = NUM_CH'($urandom_range(0, 7));
         sync   = ($urandom_range(0, 40) == 0);
         clr    = ($urandom_range(0, 250) == 0);
         wr_en  = ($urandom_range(0, 5) == 0);
         wr_ch  = CH_W'($urandom_range(0, 3));
         wr_div = CNT_W'($urandom_range(0, 9));
         step(1);
      end
      clr = 1'b0; sync = 1'b0; wr_en = 1'b0;
      step(5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/clock_enable_gen.md
Name: clock_enable_gen

Overview:
Parametrised multi-channel clock-divider / clock-enable generator for the 100 MHz master clock domain. It generalises the fixed three-output divider: N channels, each with a runtime-reprogrammable half-period divisor, per-channel enable, a 50%-duty divided output and a one-cycle tick strobe for clock-enable use. Divisor changes are glitch-free, and a sync input phase-aligns all channels. It feeds the VGA pixel timing, 7-segment scan and game-tick logic.

Parameters:
NUM_CH, 3, number of independent channels (>=1)
CNT_W, 28, counter and divisor width in bits
DIV_INIT, {28'd1000000, 28'd100000, 28'd2}, packed NUM_CH*CNT_W reset divisors; channel i at bits [i*CNT_W +: CNT_W]
CH_W, (NUM_CH>1 ? $clog2(NUM_CH) : 1), channel-select width (derived; not overridden)

Ports:
clk  in  1  master clock, 100 MHz
clr  in  1  synchronous active-high reset
en  in  1  global run enable
ch_en  in  NUM_CH  per-channel run enable
sync  in  1  synchronous phase restart of all channels
wr_en  in  1  divisor write strobe
wr_ch  in  CH_W  channel index for the write
wr_div  in  CNT_W  new half-period divisor D
div_clk  out  NUM_CH  divided 50%-duty outputs, registered
tick  out  NUM_CH  one-cycle pulse, registered, asserted in the cycle div_clk[i] rises
busy  out  NUM_CH  1 while channel i holds a pending (shadowed) divisor

Behaviour:
- Per channel: cnt[CNT_W], div_act[CNT_W], div_shd[CNT_W], pend. Output period = 2*div_act cycles; half period = div_act cycles.
- Priority per clock edge: clr > sync > write/count.
- clr=1: cnt=0, div_clk=0, tick=0, pend=0, busy=0, div_act=div_shd=DIV_INIT slice.
- run_i = en & ch_en[i] & (div_act[i]!=0). When run_i=0: cnt and div_clk hold, tick=0. D=0 means the channel is disabled and frozen.
- Counting (run_i=1): if cnt==div_act-1, then cnt<=0 and div_clk toggles. tick<=1 if div_clk was 0 (rising); else tick<=0. If pend, then div_act<=div_shd and pend<=0. Otherwise cnt<=cnt+1 and tick<=0.
- After clr release with D and run held: div_clk first rises on the D-th edge, then toggles every D edges. D=1 toggles every edge (clk/2), with tick every 2nd cycle.
- Write (wr_en=1, wr_ch<NUM_CH):
  - If the channel is running and not wrapping this cycle: div_shd<=wr_div, pend<=1. The new value takes effect at the next wrap, so the current half period is never truncated.
  - If the channel is not running, or wraps this same cycle: div_act<=wr_div directly, pend<=0. When not running, cnt<=0 as well.
  - A write while pend=1 overwrites div_shd (last write wins).
- wr_ch>=NUM_CH: the write is ignored, with no state change.
- sync=1 (clr=0): all cnt<=0, div_clk<=0, tick<=0. Every pend channel loads div_act<=div_shd, pend<=0. A write in the same cycle is applied directly to div_act of the addressed channel.
- busy[i]=pend[i] (registered).
- Channels are fully independent except for the shared clr, en, sync and the single write port.
- cnt never exceeds div_act-1 during counting. If a direct write shrinks div_act below cnt+1 on a stopped channel, cnt was already zeroed, so there is no wrap-around past 2^CNT_W.

Test Plan:
- Reset/basic: DIV_INIT={10,4,1}, en=1, ch_en=3'b111, clr held 3 cycles then released -> div_clk[0] toggles every cycle, tick[0] every 2nd cycle; div_clk[1] first rises on edge 4, period 8; div_clk[2] period 20; all outputs 0 during clr.
- Glitch-free reprogram: ch1 running at D=4, write wr_ch=1, wr_div=6 mid half-period -> busy[1]=1; current half period completes at 4 cycles; subsequent half periods are 6 cycles; busy[1] clears at that wrap.
- Stopped-channel write and disable: ch_en[2]=0, write wr_div=3 to ch2 -> div_act applied immediately, cnt=0; re-enable -> first toggle after 3 cycles. Write wr_div=0 -> ch2 frozen, tick[2]=0 indefinitely.
- Sync alignment: channels at D=4 and D=6 with arbitrary phase, pulse sync for 1 cycle -> both div_clk=0 and cnt=0 next cycle; ticks coincide every 24 cycles thereafter. A pending divisor is applied at sync.
- Simultaneous events: a write on the wrap cycle of the same channel -> new D used for the very next half period with busy never asserting. A write with wr_ch=3 (NUM_CH=3) -> no state change. clr asserted together with sync and wr_en -> pure reset values.
- Global gating: en dropped for 7 cycles mid-count -> div_clk and cnt hold, no ticks; resumes counting from the held cnt on en=1.
